raster_to_block_8x8: RTL and testbench
======================================

# raster_to_block_8x8

Converts a raster-scan pixel stream of fixed width into 8x8 blocks emitted one pixel per cycle, in row-major order within each block. It sits directly upstream of the 64-entry pixel buffer in the JPEG encoder. `out_valid`/`out_pix` drive that buffer's 1-pixel write enable and data. Two 8-line strip banks (ping-pong) let one strip be filled from the raster input while the previous strip is drained as blocks.

## Interface
- `DATA_WIDTH`, default 8: pixel width.
- `IMG_WIDTH`, default 64: pixels per image line. Must be a multiple of 8 and ≥ 8.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  raster pixel present.
- `in_ready`  out  1  block can accept a raster pixel.
- `in_sof`  in  1  start of frame; qualifies `in_pix` at a handshake.
- `in_pix`  in  DATA_WIDTH  raster pixel.
- `out_valid`  out  1  block-order pixel present.
- `out_ready`  in  1  consumer accepts; tie high when feeding the pixel buffer.
- `out_pix`  out  DATA_WIDTH  block-order pixel.
- `out_block_start`  out  1  `out_pix` is pixel 0 of a block.
- `out_block_last`  out  1  `out_pix` is pixel 63 of a block.

## Operation
- Storage: 2 banks × 8 rows × IMG_WIDTH columns × DATA_WIDTH bits. Each bank has a `full` flag.
- Write side:
  - State: counters `wcol` (0..IMG_WIDTH-1), `wrow` (0..7), and `wbank`.
  - `in_ready = !full[wbank]`, combinational.
  - On a handshake (`in_valid && in_ready`), `in_pix` is written to `[wbank][wrow][wcol]`.
  - `wcol` then increments. It wraps to 0 and increments `wrow` after IMG_WIDTH-1.
  - At `wrow==7 && wcol==IMG_WIDTH-1`: set `full[wbank]`, toggle `wbank`, and clear both counters.
- `in_sof` on a handshake:
  - The pixel is written at row 0, col 0 of the current `wbank`. `wcol` becomes 1 and `wrow` becomes 0.
  - Any partial strip is discarded. Full banks are untouched.
- Read side:
  - State: counters `blk` (0..IMG_WIDTH/8-1), `rrow` (0..7), `rcol` (0..7), and `rbank`.
  - The read address is row `rrow`, column `blk*8+rcol`.
  - The output register advances when `full[rbank]` is set and `!out_valid || out_ready` holds.
  - On advance: load `out_pix` from the read address. Set `out_block_start = (rrow==0 && rcol==0)` and `out_block_last = (rrow==7 && rcol==7)`. Set `out_valid` to 1.
  - Step order: `rcol` first, then `rrow`, then `blk`.
  - When the last address of the bank is loaded (`blk` max, `rrow==7`, `rcol==7`): clear `full[rbank]`, toggle `rbank`, and clear the counters.
  - If no advance is possible and `out_ready` is high, `out_valid` drops to 0.
- Backpressure: while `out_valid && !out_ready`, all out_* signals hold stable.
- Simultaneous events:
  - The writer setting `full[wbank]` and the reader clearing `full[rbank]` in the same cycle both take effect. The two never target the same bank.
  - `in_sof` never affects the read side.
- Width rules:
  - Column counters are `$clog2(IMG_WIDTH)` bits. `blk` is `$clog2(IMG_WIDTH/8)` bits, minimum 1.
  - No arithmetic is performed on pixel data.

## Timing
- Reset (async assert, synchronous release effect):
  - `full` = 0, all counters = 0, `wbank` = `rbank` = 0.
  - `out_valid`, `out_pix`, `out_block_start`, `out_block_last` = 0.
  - `in_ready` = 1.
  - Bank contents are not reset.
- Latency: the edge that accepts a strip's last pixel sets `full`. `out_valid` rises with the strip's first pixel at the next edge.
- Throughput: 1 pixel/cycle in and out. With `out_ready` tied high, a strip drains in 8·IMG_WIDTH cycles, equal to its fill time, so input never stalls in steady state.
- Stall: when both banks are full, `in_ready` is 0. It returns to 1 in the cycle after the reader clears `full[wbank]`.
- Reset mid-operation discards all buffered data. The first output after release requires a complete new strip.

## Test plan
- IMG_WIDTH=16, one strip, `in_pix=(row*16+col)&0xFF`, `out_ready=1`:
  - Block 0 outputs 0..7, 16..23, …, 112..119.
  - Block 1 outputs 8..15, 24..31, …, 120..127.
  - `out_block_start` is high on values 0 and 8. `out_block_last` is high on values 119 and 127.
  - `out_valid` rises one edge after the 128th input handshake.
- Three back-to-back strips with continuous `in_valid`: `in_ready` never drops and all 384 outputs are in the correct order.
- Hold `out_ready=0` while supplying 2 strips plus 1 pixel: `in_ready` is 0 after 256 handshakes, and `out_pix`, `out_valid`, and the flags stay constant.
  - Release `out_ready`: output resumes with no lost or duplicated pixel.
- Assert `in_sof` at pixel 40 of strip 1: those 40 pixels are never output, and the next complete strip drains normally.
- Assert `reset_n` low mid-drain: all outputs are 0 immediately and `in_ready=1`. After release, nothing is output until 128 new pixels are accepted.
- Toggle `out_ready` randomly: the output sequence equals the reference block-order model and every handshaked value appears exactly once.

Source files
------------

// File: rtl/raster_to_block_8x8_if.sv
// raster_to_block_8x8_if: raster-in / block-out stream bundle
// master drives in_valid/in_sof/in_pix/out_ready; slave drives in_ready and the out_* signals
interface raster_to_block_8x8_if #(parameter int DATA_WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic in_sof;
  logic [DATA_WIDTH-1:0] in_pix;
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH-1:0] out_pix;
  logic out_block_start;
  logic out_block_last;
  modport master (
    output in_valid, in_sof, in_pix, out_ready,
    input in_ready, out_valid, out_pix, out_block_start, out_block_last
  );
  modport slave (
    input in_valid, in_sof, in_pix, out_ready,
    output in_ready, out_valid, out_pix, out_block_start, out_block_last
  );
endinterface

// File: rtl/raster_to_block_8x8.sv
// raster_to_block_8x8: ping-pong 8-line strip buffer turning raster pixels into row-major 8x8 blocks
// clock, reset_n (async active-low); bus.slave: in_valid/in_ready/in_sof/in_pix raster input,
// out_valid/out_ready/out_pix/out_block_start/out_block_last block-order output
module raster_to_block_8x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 64
) (
  input logic clock,
  input logic reset_n,
  raster_to_block_8x8_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int NB = IMG_WIDTH / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  logic [DATA_WIDTH-1:0] mem [2][8][IMG_WIDTH];
  logic [1:0] full, full_set, full_clr;
  logic wbank, rbank;
  logic [CW-1:0] wcol, rd_col;
  logic [2:0] wrow, rrow, rcol;
  logic [BW-1:0] blk;
  logic in_hs, wr_end, adv, rd_end;
  logic out_valid, out_block_start, out_block_last;
  logic [DATA_WIDTH-1:0] out_pix;
  assign bus.in_ready        = !full[wbank];
  assign bus.out_valid       = out_valid;
  assign bus.out_pix         = out_pix;
  assign bus.out_block_start = out_block_start;
  assign bus.out_block_last  = out_block_last;
  always_comb begin
    in_hs    = bus.in_valid && !full[wbank];
    wr_end   = in_hs && !bus.in_sof && wrow == 3'd7 && wcol == CW'(IMG_WIDTH - 1);
    adv      = full[rbank] && (!out_valid || bus.out_ready);
    rd_end   = adv && blk == BW'(NB - 1) && rrow == 3'd7 && rcol == 3'd7;
    rd_col   = CW'({blk, rcol});
    full_set = {2{wr_end}} & (2'b01 << wbank);
    full_clr = {2{rd_end}} & (2'b01 << rbank);
  end
  // bank contents are deliberately not reset; the full flags gate every read
  always_ff @(posedge clock)
    if (in_hs)
      mem[wbank][bus.in_sof ? 3'd0 : wrow][bus.in_sof ? CW'(0) : wcol] <= bus.in_pix;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) full <= 2'b00;
    else full <= (full | full_set) & ~full_clr;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wbank <= 1'b0;
      wrow  <= 3'd0;
      wcol  <= '0;
    end else if (in_hs) begin
      if (bus.in_sof) begin
        wrow <= 3'd0;
        wcol <= CW'(1);
      end else if (wcol == CW'(IMG_WIDTH - 1)) begin
        wcol  <= '0;
        wrow  <= wrow + 3'd1;
        wbank <= wbank ^ wr_end;
      end else wcol <= wcol + 1'b1;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rbank           <= 1'b0;
      blk             <= '0;
      rrow            <= 3'd0;
      rcol            <= 3'd0;
      out_valid       <= 1'b0;
      out_pix         <= '0;
      out_block_start <= 1'b0;
      out_block_last  <= 1'b0;
    end else if (adv) begin
      out_pix         <= mem[rbank][rrow][rd_col];
      out_block_start <= rrow == 3'd0 && rcol == 3'd0;
      out_block_last  <= rrow == 3'd7 && rcol == 3'd7;
      out_valid       <= 1'b1;
      rcol            <= rcol + 3'd1;
      if (rcol == 3'd7) begin
        rrow <= rrow + 3'd1;
        if (rrow == 3'd7) begin
          blk   <= rd_end ? '0 : blk + 1'b1;
          rbank <= rbank ^ rd_end;
        end
      end
    end else if (bus.out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_raster_to_block_8x8.sv
// tb_raster_to_block_8x8: scoreboard bench for the raster-to-8x8-block converter at IMG_WIDTH=16
module tb_raster_to_block_8x8;
  localparam int DW = 8;
  localparam int IW = 16;
  localparam int SP = IW * 8;
  typedef struct packed {
    logic [7:0] pix;
    logic start;
    logic last;
  } exp_t;
  typedef struct {
    int n_pix;
    int sof_at;
    bit rnd;
    bit no_stall;
    int exp_out;
  } vec_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  raster_to_block_8x8_if #(.DATA_WIDTH(DW)) bus();
  raster_to_block_8x8 #(.DATA_WIDTH(DW), .IMG_WIDTH(IW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  exp_t exp_q[$];
  logic [7:0] sbuf [SP];
  int wp, n_out, pass_n, total_n;
  bit stall_seen, out_seen;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic model_accept(input bit sof, input logic [7:0] p);
    exp_t e;
    if (sof) wp = 0;
    sbuf[wp] = p;
    wp++;
    if (wp == SP) begin
      for (int b = 0; b < IW / 8; b++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            e.pix = sbuf[r * IW + b * 8 + c];
            e.start = (r == 0 && c == 0);
            e.last = (r == 7 && c == 7);
            exp_q.push_back(e);
          end
      wp = 0;
    end
  endtask
  task automatic step(input bit iv, input bit sof, input logic [7:0] p, input bit ordy, output bit acc);
    exp_t e;
    bus.in_valid = iv;
    bus.in_sof = sof;
    bus.in_pix = p;
    bus.out_ready = ordy;
    acc = 0;
    @(negedge clock);
    if (bus.out_valid) out_seen = 1;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        total_n++;
        $display("FAIL extra_output: got pixel %0d expected no output", bus.out_pix);
      end else begin
        e = exp_q.pop_front();
        chk("out_pix", 32'(bus.out_pix), 32'(e.pix));
        chk("out_block_start", 32'(bus.out_block_start), 32'(e.start));
        chk("out_block_last", 32'(bus.out_block_last), 32'(e.last));
      end
    end
    if (iv && !bus.in_ready) stall_seen = 1;
    if (iv && bus.in_ready) begin
      model_accept(sof, p);
      acc = 1;
    end
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    bus.in_valid = 0;
    bus.in_sof = 0;
    bus.in_pix = '0;
    bus.out_ready = 0;
    exp_q.delete();
    wp = 0;
    n_out = 0;
    stall_seen = 0;
    out_seen = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask
  task automatic drain(input bit rnd);
    bit acc;
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      step(0, 0, 8'd0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      cyc++;
    end
    repeat (4) step(0, 0, 8'd0, 1, acc);
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    bit acc;
    int k = 0;
    int cyc = 0;
    do_reset();
    while (k < v.n_pix && cyc < 4000) begin
      step(1, k == v.sof_at, 8'(k + idx * 5), v.rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      if (acc) k++;
      cyc++;
    end
    drain(v.rnd);
    chk($sformatf("vec%0d_out_count", idx), 32'(n_out), 32'(v.exp_out));
    if (v.no_stall) chk($sformatf("vec%0d_no_stall", idx), 32'(stall_seen), 32'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vecs[5];
    bit acc;
    int k, cyc;
    pass_n = 0;
    total_n = 0;
    vecs[0] = '{n_pix: 128, sof_at: -1, rnd: 0, no_stall: 1, exp_out: 128};
    vecs[1] = '{n_pix: 384, sof_at: -1, rnd: 0, no_stall: 1, exp_out: 384};
    vecs[2] = '{n_pix: 168, sof_at: 40, rnd: 0, no_stall: 1, exp_out: 128};
    vecs[3] = '{n_pix: 512, sof_at: -1, rnd: 1, no_stall: 0, exp_out: 512};
    vecs[4] = '{n_pix: 100, sof_at: -1, rnd: 0, no_stall: 1, exp_out: 0};
    do_reset();
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_pix", 32'(bus.out_pix), 32'd0);
    chk("reset_block_start", 32'(bus.out_block_start), 32'd0);
    chk("reset_block_last", 32'(bus.out_block_last), 32'd0);
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    do_reset();
    for (int i = 0; i < 128; i++) step(1, 0, 8'(i), 1, acc);
    chk("lat_valid_low_at_fill", 32'(bus.out_valid), 32'd0);
    step(0, 0, 8'd0, 1, acc);
    chk("lat_valid_high", 32'(bus.out_valid), 32'd1);
    chk("lat_first_start", 32'(bus.out_block_start), 32'd1);
    chk("lat_first_pix", 32'(bus.out_pix), 32'd0);
    drain(0);
    chk("lat_out_count", 32'(n_out), 32'd128);
    do_reset();
    k = 0;
    cyc = 0;
    while (k < 256 && cyc < 1000) begin
      step(1, 0, 8'(k), 0, acc);
      if (acc) k++;
      cyc++;
    end
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (20) begin
      step(1, 0, 8'(k), 0, acc);
      if (acc) k++;
    end
    chk("bp_no_accept", 32'(k), 32'd256);
    chk("bp_in_ready_still_low", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_hold_pix", 32'(bus.out_pix), 32'd0);
    chk("bp_hold_start", 32'(bus.out_block_start), 32'd1);
    chk("bp_hold_last", 32'(bus.out_block_last), 32'd0);
    cyc = 0;
    while ((exp_q.size() > 0 || k < 257) && cyc < 2000) begin
      step(k < 257, 0, 8'(k), 1, acc);
      if (acc) k++;
      cyc++;
    end
    chk("bp_out_count", 32'(n_out), 32'd256);
    chk("bp_extra_pixel_taken", 32'(k), 32'd257);
    do_reset();
    for (int i = 0; i < 128; i++) step(1, 0, 8'(i * 3), 1, acc);
    repeat (10) step(0, 0, 8'd0, 1, acc);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_pix", 32'(bus.out_pix), 32'd0);
    chk("mid_rst_block_start", 32'(bus.out_block_start), 32'd0);
    chk("mid_rst_block_last", 32'(bus.out_block_last), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    wp = 0;
    n_out = 0;
    out_seen = 0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 127; i++) step(1, 0, 8'(i + 9), 1, acc);
    repeat (5) step(0, 0, 8'd0, 1, acc);
    chk("post_rst_no_output", 32'(out_seen), 32'd0);
    step(1, 0, 8'd200, 1, acc);
    drain(0);
    chk("post_rst_out_count", 32'(n_out), 32'd128);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
